// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings and
// baud-rate helpers, so the receive side can reuse the same values.
package uart_tx_buffered_pkg;

    // 2-bit line FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Clock cycles per serial bit, integer-truncated
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // True when n is a non-zero power of two
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Small synchronous FIFO, first-word fall-through: rd_data is valid while
// empty is low. A write while full is dropped even if a pop happens in the
// same cycle.
module sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_ok, rd_ok;

    assign wr_ok   = wr_en & ~full_q;
    assign rd_ok   = rd_en & ~empty_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next pointers/occupancy; flags follow the next count so they are registered
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, written only on accepted writes
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and a baud-timed FSM
// shifts them out LSB first, back to back with no idle gap between frames.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       uart_tx
);
    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = (CPB < 2) ? 1 : $clog2(CPB);

    if (CPB < 2) begin : g_cpb_chk
        $error("uart_tx_buffered: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_done;
    logic        pop;
    logic [7:0]  fifo_data;
    logic        fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign empty    = fifo_empty;
    assign bit_done = (baud_q == BW'(CPB - 1));
    assign busy     = (state_q != ST_IDLE);
    assign uart_tx  = tx_q;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic; pops happen from IDLE or at the end of the stop bit
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: if (bit_done) state_d = ST_DATA;
            ST_DATA:  if (bit_done && bit_cnt_q == 3'd7) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs/datapath: baud counter restarts at each bit, so at every state entry;
    // line level is registered from the next state to stay glitch-free
    always_comb begin
        baud_d    = (state_q == ST_IDLE || bit_done) ? '0 : baud_q + BW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (pop) begin
            bit_cnt_d = '0;
            shift_d   = fifo_data;
        end else if (state_q == ST_DATA && bit_done) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
        end
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
